// File: rtl/filters_dline_seq.sv
// filters_dline_seq: circular-buffer history sequencer that streams NTAPS newest-to-oldest taps per sample.
// Define FILTERS_DLINE_OVERRUN_EN to build the sticky overrun detector.
module filters_dline_seq #(
   parameter int DWIDTH = 16,
   parameter int NTAPS  = 32,
   parameter int AWIDTH = $clog2(NTAPS)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              sample_valid,
   input  logic [DWIDTH-1:0] sample_data,
   output logic              sample_ready,
   input  logic              flush,
   output logic              busy,
   output logic [AWIDTH-1:0] ram_wraddr,
   output logic [AWIDTH-1:0] ram_rdaddr,
   output logic              ram_wren,
   output logic [DWIDTH-1:0] ram_d,
   input  logic [DWIDTH-1:0] ram_q,
   output logic              tap_valid,
   output logic [DWIDTH-1:0] tap_data,
   output logic [AWIDTH-1:0] tap_idx,
   output logic              tap_last,
   output logic              overrun
);
   localparam logic [AWIDTH-1:0] LAST = AWIDTH'(NTAPS - 1);
   typedef enum logic [1:0] {CLEAR, IDLE, READ} state_t;
   state_t state_q, state_d;
   logic [AWIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AWIDTH-1:0] rd_cnt_q, rd_cnt_d, clr_cnt_q, clr_cnt_d, tap_idx_q;
   logic              tap_valid_q, tap_last_q;
   always_comb begin
      state_d      = state_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      rd_cnt_d     = rd_cnt_q;
      clr_cnt_d    = clr_cnt_q;
      ram_wren     = 1'b0;
      ram_wraddr   = wr_ptr_q;
      ram_d        = sample_data;
      sample_ready = 1'b0;
      case (state_q)
         CLEAR: begin
            ram_wren   = 1'b1;
            ram_wraddr = clr_cnt_q;
            ram_d      = '0;
            clr_cnt_d  = (clr_cnt_q == LAST) ? '0 : clr_cnt_q + AWIDTH'(1);
            if (clr_cnt_q == LAST) begin
               state_d  = IDLE;
               wr_ptr_d = '0;
            end
         end
         IDLE: begin
            sample_ready = !flush;
            if (flush) begin
               state_d   = CLEAR;
               clr_cnt_d = '0;
            end else if (sample_valid) begin
               ram_wren = 1'b1;
               rd_ptr_d = wr_ptr_q;
               rd_cnt_d = '0;
               state_d  = READ;
            end
         end
         READ: begin
            rd_ptr_d = (rd_ptr_q == '0) ? LAST : rd_ptr_q - AWIDTH'(1);
            rd_cnt_d = rd_cnt_q + AWIDTH'(1);
            if (rd_cnt_q == LAST) begin
               wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + AWIDTH'(1);
               state_d  = IDLE;
            end
         end
         default: state_d = CLEAR;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= CLEAR;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         rd_cnt_q    <= '0;
         clr_cnt_q   <= '0;
         tap_valid_q <= 1'b0;
         tap_idx_q   <= '0;
         tap_last_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         rd_cnt_q    <= rd_cnt_d;
         clr_cnt_q   <= clr_cnt_d;
         tap_valid_q <= state_q == READ;
         tap_idx_q   <= rd_cnt_q;
         tap_last_q  <= state_q == READ && rd_cnt_q == LAST;
      end
   end
   // Tap tags are delayed one cycle to line up with the RAM's registered read data.
   assign ram_rdaddr = rd_ptr_q;
   assign busy       = state_q != IDLE;
   assign tap_valid  = tap_valid_q;
   assign tap_idx    = tap_idx_q;
   assign tap_last   = tap_last_q;
   assign tap_data   = ram_q;
`ifdef FILTERS_DLINE_OVERRUN_EN
   logic overrun_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) overrun_q <= 1'b0;
      else if (state_q == IDLE && flush) overrun_q <= 1'b0;
      else if (sample_valid && state_q != IDLE) overrun_q <= 1'b1;
   end
   assign overrun = overrun_q;
`else
   assign overrun = 1'b0;
`endif
endmodule

// File: doc/filters_dline_seq.md
Name: filters_dline_seq

Overview:
- Circular-buffer sample history sequencer for FIR-type filters. Drives the address, write-enable and data ports of an external `filters_ram` instance and consumes its read data.
- On each accepted input sample:
  - writes the sample into the history;
  - streams the newest-to-oldest NTAPS history words to a downstream MAC stage, one per cycle, tagged with the tap index.
- Clears the history after reset and on request.

Parameters:
- DWIDTH, 16, sample width; must match the RAM DWIDTH.
- NTAPS, 32, history depth (taps per output); legal range 2 or more; need not be a power of two.
- AWIDTH, $clog2(NTAPS), derived RAM address width; not to be overridden.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- sample_valid  in  1  input sample strobe.
- sample_data  in  DWIDTH  input sample.
- sample_ready  out  1  block can accept a sample this cycle.
- flush  in  1  request history clear; sampled in IDLE only.
- busy  out  1  high whenever state is not IDLE.
- ram_wraddr  out  AWIDTH  to RAM wraddr.
- ram_rdaddr  out  AWIDTH  to RAM rdaddr.
- ram_wren  out  1  to RAM wren.
- ram_d  out  DWIDTH  to RAM d.
- ram_q  in  DWIDTH  from RAM q; RAM read latency is 1 cycle.
- tap_valid  out  1  tap_data/tap_idx/tap_last valid.
- tap_data  out  DWIDTH  history word; combinational pass-through of ram_q.
- tap_idx  out  AWIDTH  0 = newest sample, NTAPS-1 = oldest.
- tap_last  out  1  high with tap_idx == NTAPS-1.
- overrun  out  1  sticky overrun flag (see Optional Feature).

Behaviour:
- Clock, reset: one clock `clk`; asynchronous active-low reset `rst_n`.
- Reset values:
  - state = CLEAR; wr_ptr = 0; clr_cnt = 0.
  - tap_valid = 0, tap_idx = 0, tap_last = 0, overrun = 0.
  - sample_ready = 0, busy = 1.
  - While reset is held, ram_wren = 1 and ram_d = 0 at address 0; this is harmless.
- States:
  - CLEAR:
    - ram_wren = 1, ram_wraddr = clr_cnt, ram_d = 0.
    - clr_cnt counts 0..NTAPS-1, then goes to IDLE with wr_ptr = 0.
    - Lasts exactly NTAPS cycles.
  - IDLE:
    - sample_ready = !flush.
    - If flush = 1: enter CLEAR with clr_cnt = 0; any sample_valid in that cycle is not accepted (flush wins).
    - Else if sample_valid = 1: accept. ram_wren = 1, ram_wraddr = wr_ptr, ram_d = sample_data. Load rd_ptr = wr_ptr and rd_cnt = 0, then go to READ.
  - READ:
    - ram_rdaddr = rd_ptr; ram_wren = 0.
    - Each cycle: rd_ptr decrements with wrap (0 becomes NTAPS-1) and rd_cnt increments.
    - On the cycle rd_cnt == NTAPS-1: wr_ptr becomes (wr_ptr == NTAPS-1) ? 0 : wr_ptr+1, and the state goes to IDLE.
- Outputs outside these conditions: ram_wren = 0, ram_rdaddr = rd_ptr, ram_wraddr = wr_ptr, ram_d = sample_data.
- Output pipeline: tap_valid, tap_idx and tap_last are registered copies of (state==READ, rd_cnt, rd_cnt==NTAPS-1). This aligns them with ram_q one cycle after the read is issued.
- Read-after-write: the first read is issued the cycle after the write, so the RAM returns the new sample. No bypass logic is needed.
- Timing, with the accept in cycle t:
  - tap 0 appears at t+2;
  - tap_last appears at t+NTAPS+1;
  - the next accept is possible at t+NTAPS+1;
  - minimum sample period is NTAPS+1 cycles.
- A sample accepted in the cycle tap_last is output is legal. It writes the new wr_ptr location, which no in-flight read is using.
- sample_valid while sample_ready = 0 is dropped; there is no buffering.
- flush asserted outside IDLE is ignored.
- Reset mid-operation: the in-flight tap sequence is aborted immediately (tap_valid = 0), then a full CLEAR runs.

Optional Feature:
- Macro: FILTERS_DLINE_OVERRUN_EN.
- Defined:
  - overrun sets when sample_valid = 1 while state is READ or CLEAR.
  - It stays set until reset, or until a flush is taken in IDLE.
- Undefined: overrun is tied to 0 and no detection logic is built. The port list is identical in both cases.

Test Plan (NTAPS=4, DWIDTH=16, bench attaches a filters_ram model):
- Reset release:
  - ram_wren = 1 with ram_wraddr 0,1,2,3 and ram_d = 0 over 4 cycles;
  - sample_ready = 1 in the 5th cycle; busy = 0 in that same cycle.
- First sample 0x0011 after clear: tap_data 0x0011, 0, 0, 0 with tap_idx 0..3; tap_last only on idx 3; tap 0 two cycles after accept.
- Samples 1,2,3,4,5 streamed at the maximum rate (every 5 cycles):
  - after sample 5, taps are 5,4,3,2;
  - sample 5 is written to address 0;
  - reads are at addresses 0,3,2,1.
- flush and sample_valid (value 0x7) asserted together in IDLE: sample is not accepted; 4 zero writes follow; the next sample 0x9 yields taps 9,0,0,0.
- sample_valid pulsed in the 2nd READ cycle: sample is dropped and the taps are unaffected. With FILTERS_DLINE_OVERRUN_EN, overrun = 1 and stays 1 until a flush in IDLE returns it to 0.
- rst_n asserted during READ at tap_idx 1: tap_valid drops to 0 asynchronously; after release, a full 4-cycle CLEAR runs and the next sample yields x,0,0,0.
